square_channel_controller: RTL

//  Register-programmed controller for one square-wave voice. Decodes CPU sound-register writes and runs
//  the 512 Hz frame sequencer: length counter, volume envelope, optional frequency sweep. Drives the

---
 rtl/gbc_sound_pkg.sv | 30 +++
 rtl/sound_frame_sequencer.sv | 50 +++++
 rtl/square_channel_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gbc_sound_pkg.sv
// gbc_sound_pkg: shared register map, field positions, limits and frame-sequencer step masks
//   for the square-channel controller and the frame sequencer.
//   Channel state is bundled into ch_state_t so the controller can reset or clear it as one register.
package gbc_sound_pkg;
    localparam logic [2:0] ADDR_SWEEP    = 3'd0;
    localparam logic [2:0] ADDR_DUTY_LEN = 3'd1;
    localparam logic [2:0] ADDR_ENV      = 3'd2;
    localparam logic [2:0] ADDR_FREQ_LO  = 3'd3;
    localparam logic [2:0] ADDR_FREQ_HI  = 3'd4;
    localparam int TRIG_BIT   = 7;
    localparam int LEN_EN_BIT = 6;
    localparam int ENV_UP_BIT = 3;
    localparam logic [6:0] LEN_MAX = 7'd64;
    localparam logic [3:0] VOL_MAX = 4'd15;
    // Bit n set means the clock fires when step n is entered.
    localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;
    typedef struct packed {
        logic [10:0] freq;
        logic [1:0]  duty;
        logic        pulse;
        logic        en;
        logic [3:0]  vol;
        logic [6:0]  len;
        logic        len_en;
        logic [7:0]  env;
        logic [2:0]  env_t;
    } ch_state_t;
endpackage

// File: rtl/sound_frame_sequencer.sv
// sound_frame_sequencer: 512 Hz frame sequencer shared by the sound channels.
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset
//   i_enable     master sound enable; low holds prescaler and step at 0
//   o_len_clk    one-cycle pulse on entering steps 0,2,4,6
//   o_sweep_clk  one-cycle pulse on entering steps 2,6
//   o_env_clk    one-cycle pulse on entering step 7
module sound_frame_sequencer
    import gbc_sound_pkg::*;
#(
    parameter int CLKS_PER_STEP = 8192
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_enable,
    output logic o_len_clk,
    output logic o_sweep_clk,
    output logic o_env_clk
);
    localparam int PW = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    step_q, step_d;
    logic [2:0]    clk_q, clk_d;
    logic          wrap;

    // Pulses are registered so they are high during the first cycle of the new step.
    always_comb begin
        wrap    = presc_q == PW'(CLKS_PER_STEP - 1);
        presc_d = (!i_enable || wrap) ? '0 : presc_q + PW'(1);
        step_d  = !i_enable ? '0 : step_q + {2'b0, wrap};
        clk_d   = (i_enable && wrap) ? {ENV_STEPS[step_d], SWEEP_STEPS[step_d], LEN_STEPS[step_d]} : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            step_q  <= '0;
            clk_q   <= '0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            clk_q   <= clk_d;
        end
    end

    assign o_len_clk   = clk_q[0];
    assign o_sweep_clk = clk_q[1];
    assign o_env_clk   = clk_q[2];
endmodule

// File: rtl/square_channel_controller.sv
// square_channel_controller: register decode, length counter, envelope and optional sweep for one square voice.
//   I_CLK / I_RESET_N   clock, asynchronous active-low reset
//   I_SOUND_ON          master enable; low clears all state and ignores writes
//   I_REG_WE/ADDR/DATA  CPU register write (0 sweep, 1 duty/len, 2 env, 3 freq lo, 4 freq hi/ctrl)
//   O_FREQUENCY, O_DUTY_CYCLE, O_WRITE_NEW_SOUND, O_WAVEFORM_EN  to the waveform generator
//   O_VOLUME            envelope volume to the mixer
//   Define SQUARE_SWEEP_EN to build the frequency sweep unit; without it r0 writes are ignored.
module square_channel_controller
    import gbc_sound_pkg::*;
#(
    parameter int CLKS_PER_STEP = 8192
) (
    input  logic        I_CLK,
    input  logic        I_RESET_N,
    input  logic        I_SOUND_ON,
    input  logic        I_REG_WE,
    input  logic [2:0]  I_REG_ADDR,
    input  logic [7:0]  I_REG_DATA,
    output logic [10:0] O_FREQUENCY,
    output logic [1:0]  O_DUTY_CYCLE,
    output logic        O_WRITE_NEW_SOUND,
    output logic        O_WAVEFORM_EN,
    output logic [3:0]  O_VOLUME
);
    ch_state_t s_q, s_d;
    logic w0, w1, w2, w3, w4, trig;
    logic len_clk, sweep_clk, env_clk;

    sound_frame_sequencer #(.CLKS_PER_STEP(CLKS_PER_STEP)) u_seq (
        .i_clk      (I_CLK),
        .i_reset_n  (I_RESET_N),
        .i_enable   (I_SOUND_ON),
        .o_len_clk  (len_clk),
        .o_sweep_clk(sweep_clk),
        .o_env_clk  (env_clk)
    );

`ifdef SQUARE_SWEEP_EN
    logic [6:0]  sw_q, sw_d;
    logic [10:0] shadow_q, shadow_d, sw_src;
    logic [11:0] sw_delta, sw_new;
    logic [3:0]  swt_q, swt_d, sw_reload;
    logic        sw_ovf;
`else
    logic unused_sweep;
    assign unused_sweep = sweep_clk ^ w0;
`endif

    // A register write wins over any sequencer clock that would touch the same fields this cycle.
    always_comb begin
        w0   = I_REG_WE && I_REG_ADDR == ADDR_SWEEP;
        w1   = I_REG_WE && I_REG_ADDR == ADDR_DUTY_LEN;
        w2   = I_REG_WE && I_REG_ADDR == ADDR_ENV;
        w3   = I_REG_WE && I_REG_ADDR == ADDR_FREQ_LO;
        w4   = I_REG_WE && I_REG_ADDR == ADDR_FREQ_HI;
        trig = w4 && I_REG_DATA[TRIG_BIT];
        s_d       = s_q;
        s_d.pulse = w1 || w3 || w4;
        if (w1) begin
            s_d.duty = I_REG_DATA[7:6];
            s_d.len  = LEN_MAX - {1'b0, I_REG_DATA[5:0]};
        end else if (len_clk && !w4 && s_q.len_en && s_q.len != '0) begin
            s_d.len = s_q.len - 7'd1;
            if (s_q.len == 7'd1) s_d.en = 1'b0;
        end
        if (w2) s_d.env = I_REG_DATA;
        if (w3) s_d.freq[7:0] = I_REG_DATA;
        if (w4) begin
            s_d.freq[10:8] = I_REG_DATA[2:0];
            s_d.len_en     = I_REG_DATA[LEN_EN_BIT];
        end
        if (trig) begin
            s_d.en    = s_q.env[7:3] != '0;
            s_d.len   = (s_q.len == '0) ? LEN_MAX : s_q.len;
            s_d.vol   = s_q.env[7:4];
            s_d.env_t = s_q.env[2:0];
        end else if (env_clk && !w2 && s_q.env[2:0] != '0) begin
            if (s_q.env_t <= 3'd1) begin
                s_d.env_t = s_q.env[2:0];
                s_d.vol   = s_q.env[ENV_UP_BIT] ? (s_q.vol == VOL_MAX ? s_q.vol : s_q.vol + 4'd1)
                                                : (s_q.vol == '0 ? s_q.vol : s_q.vol - 4'd1);
            end else begin
                s_d.env_t = s_q.env_t - 3'd1;
            end
        end
`ifdef SQUARE_SWEEP_EN
        sw_d      = w0 ? I_REG_DATA[6:0] : sw_q;
        shadow_d  = shadow_q;
        swt_d     = swt_q;
        // On trigger the check runs against the frequency being loaded, not the old shadow.
        sw_src    = trig ? {I_REG_DATA[2:0], s_q.freq[7:0]} : shadow_q;
        sw_delta  = {1'b0, sw_src >> sw_q[2:0]};
        sw_new    = sw_q[3] ? {1'b0, sw_src} - sw_delta : {1'b0, sw_src} + sw_delta;
        sw_ovf    = !sw_q[3] && sw_new[11];
        sw_reload = (sw_q[6:4] != '0) ? {1'b0, sw_q[6:4]} : 4'd8;
        if (trig) begin
            shadow_d = sw_src;
            swt_d    = sw_reload;
            if (sw_q[2:0] != '0 && sw_ovf) s_d.en = 1'b0;
        end else if (sweep_clk && !w0 && !w3 && !w4) begin
            if (swt_q <= 4'd1) begin
                swt_d = sw_reload;
                if (sw_q[6:4] != '0 && sw_ovf) begin
                    s_d.en = 1'b0;
                end else if (sw_q[6:4] != '0 && sw_q[2:0] != '0) begin
                    shadow_d  = sw_new[10:0];
                    s_d.freq  = sw_new[10:0];
                    s_d.pulse = 1'b1;
                end
            end else begin
                swt_d = swt_q - 4'd1;
            end
        end
        if (!I_SOUND_ON) begin
            sw_d     = '0;
            shadow_d = '0;
            swt_d    = '0;
        end
`endif
        if (!I_SOUND_ON) s_d = '0;
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) s_q <= '0;
        else s_q <= s_d;
    end

`ifdef SQUARE_SWEEP_EN
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            sw_q     <= '0;
            shadow_q <= '0;
            swt_q    <= '0;
        end else begin
            sw_q     <= sw_d;
            shadow_q <= shadow_d;
            swt_q    <= swt_d;
        end
    end
`endif

    assign O_FREQUENCY       = s_q.freq;
    assign O_DUTY_CYCLE      = s_q.duty;
    assign O_WRITE_NEW_SOUND = s_q.pulse;
    assign O_WAVEFORM_EN     = s_q.en;
    assign O_VOLUME          = s_q.vol;
endmodule
